// File: rtl/tpu_stream_loader.sv
// Host-to-TPU ingress stage. It checks frame length, pads short frames, truncates long ones,
// and feeds the TPU through a first-word-fall-through FIFO.
module tpu_stream_loader #(
  parameter int A     = 4,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        tpu_ready,
  output logic        tpu_valid,
  output logic [31:0] tpu_data,
  output logic        tpu_enable,
  output logic        frame_err,
  output logic [15:0] frames_done,
  output logic        busy
);

  localparam int FRAME_LEN = A * (N + M);
  localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            frame_err_q, frame_err_d;
  logic            enable_q, enable_d;
  logic [15:0]     frames_done_q, frames_done_d;
  logic            busy_q, busy_d;
  logic [31:0]     last_data_q, last_data_d;

  // Each entry is {last_flag, data}; read combinationally for fall-through.
  logic [32:0]     mem_q [DEPTH];
  logic [32:0]     head;

  logic            fifo_full;
  logic            push;
  logic            push_last;
  logic            push_first;
  logic [31:0]     push_word;
  logic            pop;
  logic            s_ready_c;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    frame_err_d   = 1'b0;
    push          = 1'b0;
    push_last     = 1'b0;
    push_first    = 1'b0;
    push_word     = 32'h0;
    s_ready_c     = 1'b0;
    fifo_full     = (count_q == FULL_CNT);

    case (state_q)
      IDLE, LOAD: begin
        s_ready_c = !fifo_full;
        if (s_valid && s_ready_c) begin
          push       = 1'b1;
          push_word  = s_data;
          push_last  = (wcnt_q == WCNT_LAST);
          push_first = (wcnt_q == '0);
          if (wcnt_q == WCNT_LAST) begin
            wcnt_d  = '0;
            state_d = s_last ? IDLE : DISCARD;
          end else if (s_last) begin
            wcnt_d      = wcnt_q + WCW'(1);
            frame_err_d = 1'b1;
            state_d     = PAD;
          end else begin
            wcnt_d  = wcnt_q + WCW'(1);
            state_d = LOAD;
          end
        end
      end
      PAD: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_last = (wcnt_q == WCNT_LAST);
          if (wcnt_q == WCNT_LAST) begin
            wcnt_d  = '0;
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      DISCARD: begin
        s_ready_c = 1'b1;
        if (s_valid && s_last) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    pop           = (count_q != '0) && tpu_ready;
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    last_data_d   = pop ? head[31:0] : last_data_q;
    frames_done_d = (pop && head[32]) ? frames_done_q + 16'd1 : frames_done_q;
    // Keep enable high while a following frame already occupies the FIFO.
    enable_d = enable_q;
    if (pop && head[32] && count_q == CW'(1)) enable_d = 1'b0;
    if (push_first) enable_d = 1'b1;
    busy_d = (state_d != IDLE) || (wcnt_d != '0) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_err_q   <= 1'b0;
      enable_q      <= 1'b0;
      frames_done_q <= 16'h0;
      busy_q        <= 1'b0;
      last_data_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_err_q   <= frame_err_d;
      enable_q      <= enable_d;
      frames_done_q <= frames_done_d;
      busy_q        <= busy_d;
      last_data_q   <= last_data_d;
    end
  end

  assign s_ready     = s_ready_c;
  assign tpu_valid   = (count_q != '0);
  assign tpu_data    = (count_q != '0) ? head[31:0] : last_data_q;
  assign tpu_enable  = enable_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tpu_stream_loader.sv
// Directed bench for tpu_stream_loader: exact, backpressured, short, long, back-to-back
// and reset-interrupted frames, all checked against hand-built expected word lists.
module tb_tpu_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        tpu_ready;
  logic        tpu_valid;
  logic [31:0] tpu_data;
  logic        tpu_enable;
  logic        frame_err;
  logic [15:0] frames_done;
  logic        busy;

  int vec_cnt    = 0;
  int miscompare = 0;

  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];
  int          err_cnt  = 0;
  int          en_bad   = 0;
  int          en_falls = 0;
  logic        en_prev  = 1'b0;

  tpu_stream_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tpu_ready   (tpu_ready),
    .tpu_valid   (tpu_valid),
    .tpu_data    (tpu_data),
    .tpu_enable  (tpu_enable),
    .frame_err   (frame_err),
    .frames_done (frames_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Transfers are predicted at the falling edge; inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tpu_valid && tpu_ready) begin
        rx_q.push_back(tpu_data);
        if (!tpu_enable) en_bad++;
      end
      if (frame_err) err_cnt++;
      if (en_prev && !tpu_enable) en_falls++;
    end
    en_prev = tpu_enable;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_bound", 32'(guard < 300), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_range(input int first, input int cnt, input bit last_at_end);
    for (int i = 0; i < cnt; i++)
      send_word(32'(first + i), last_at_end && (i == cnt - 1));
  endtask

  task automatic expect_range(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(32'(first + i));
  endtask

  task automatic wait_drain();
    int guard = 0;
    @(negedge clk);
    while ((tpu_valid || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_bound", 32'(guard < 500), 32'd1);
    step();
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] got;
    check_eq({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF;
      check_eq($sformatf("%s_w%0d", tag, i), got, exp_q[i]);
    end
    $display("frame %s: %0d words received, %0d expected", tag, rx_q.size(), exp_q.size());
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"},  32'(tpu_valid),   32'd0);
    check_eq({tag, "_data"},   tpu_data,         32'd0);
    check_eq({tag, "_enable"}, 32'(tpu_enable),  32'd0);
    check_eq({tag, "_err"},    32'(frame_err),   32'd0);
    check_eq({tag, "_done"},   32'(frames_done), 32'd0);
    check_eq({tag, "_busy"},   32'(busy),        32'd0);
    check_eq({tag, "_sready"}, 32'(s_ready),     32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = 32'h0;
    s_last    = 1'b0;
    tpu_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Exact frame
    send_range(1, 32, 1'b1);
    wait_drain();
    expect_range(1, 32);
    check_rx("exact");
    check_eq("exact_done",   32'(frames_done), 32'd1);
    check_eq("exact_err",    32'(err_cnt),     32'd0);
    check_eq("exact_en_bad", 32'(en_bad),      32'd0);
    check_eq("exact_busy",   32'(busy),        32'd0);
    check_eq("exact_enable", 32'(tpu_enable),  32'd0);
    check_eq("exact_hold",   tpu_data,         32'd32);

    // Backpressure: 8 fill the FIFO, the 9th must stall
    tpu_ready = 1'b0;
    send_range(101, 8, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'd109;
    s_last  = 1'b0;
    repeat (3) step();
    check_eq("bp_sready", 32'(s_ready),   32'd0);
    check_eq("bp_valid",  32'(tpu_valid), 32'd1);
    check_eq("bp_hold",   tpu_data,       32'd101);
    tpu_ready = 1'b1;
    send_range(109, 24, 1'b1);
    wait_drain();
    expect_range(101, 32);
    check_rx("bp");
    check_eq("bp_done", 32'(frames_done), 32'd2);

    // Short frame: 5 words then 27 zero pads
    send_range(201, 5, 1'b1);
    check_eq("short_err_pulse", 32'(frame_err), 32'd1);
    check_eq("short_pad_sready", 32'(s_ready),  32'd0);
    wait_drain();
    expect_range(201, 5);
    for (int i = 0; i < 27; i++) exp_q.push_back(32'h0);
    check_rx("short");
    check_eq("short_err_cnt", 32'(err_cnt),     32'd1);
    check_eq("short_done",    32'(frames_done), 32'd3);

    // Long frame: 40 words, only the first 32 reach the TPU
    err_cnt = 0;
    send_range(301, 39, 1'b0);
    check_eq("long_no_early_err", 32'(err_cnt), 32'd0);
    send_word(32'd340, 1'b1);
    check_eq("long_err_pulse", 32'(frame_err), 32'd1);
    wait_drain();
    expect_range(301, 32);
    check_rx("long");
    check_eq("long_err_cnt", 32'(err_cnt),     32'd1);
    check_eq("long_done",    32'(frames_done), 32'd4);

    // Back-to-back exact frames
    err_cnt  = 0;
    en_falls = 0;
    en_bad   = 0;
    send_range(401, 32, 1'b1);
    send_range(501, 32, 1'b1);
    wait_drain();
    expect_range(401, 32);
    expect_range(501, 32);
    check_rx("b2b");
    check_eq("b2b_en_falls", 32'(en_falls),    32'd1);
    check_eq("b2b_en_bad",   32'(en_bad),      32'd0);
    check_eq("b2b_done",     32'(frames_done), 32'd6);
    check_eq("b2b_err",      32'(err_cnt),     32'd0);

    // Reset in the middle of a frame
    send_range(601, 12, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rx_q.delete();
    rst = 1'b0;
    step();
    send_range(701, 32, 1'b1);
    wait_drain();
    expect_range(701, 32);
    check_rx("after_rst");
    check_eq("after_rst_done", 32'(frames_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare);
    $finish;
  end

endmodule
